// File: rtl/cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-back cache controller:
// FSM encoding, tag-entry field positions and address split helper.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_IDLE,
    S_LOOKUP,
    S_WB_RD,
    S_WB_WR,
    S_RF_REQ,
    S_REPLAY,
    S_DONE
  } state_t;

  // Lowest address bit belonging to the tag field.
  function automatic int calc_addr_lsb(input int lines, input int wpb);
    return $clog2(lines) + $clog2(wpb) + 2;
  endfunction

  function automatic int valid_bit(input int tag_len);
    return tag_len - 1;
  endfunction

  function automatic int dirty_bit(input int tag_len);
    return tag_len - 2;
  endfunction

endpackage

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back cache controller: CPU word port in front of a
// cache way (1-cycle data RAM, combinational tags) and a word-wide memory.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int LINES           = 128,
  parameter int WORDS_PER_BLOCK = 32,
  parameter int TAG_LENGTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           a,
  input  logic [31:0]           d,
  input  logic                  we,
  input  logic                  rd,
  output logic [31:0]           spo,
  output logic                  ready,
  output logic                  way_en,
  output logic [31:0]           way_a,
  output logic [31:0]           way_d,
  output logic                  way_we,
  input  logic [31:0]           way_spo,
  output logic                  tag_we,
  output logic [TAG_LENGTH-1:0] tag_in,
  input  logic [TAG_LENGTH-1:0] tag_out,
  input  logic                  way_init_done,
  output logic [31:0]           mem_a,
  output logic [31:0]           mem_d,
  output logic                  mem_we,
  output logic                  mem_rd,
  input  logic [31:0]           mem_spo,
  input  logic                  mem_ready
);

  localparam int OFS_W    = $clog2(WORDS_PER_BLOCK);
  localparam int IDX_W    = $clog2(LINES);
  localparam int ADDR_LSB = calc_addr_lsb(LINES, WORDS_PER_BLOCK);
  localparam int TAG_W    = 32 - ADDR_LSB;
  localparam int VB       = valid_bit(TAG_LENGTH);
  localparam int DB       = dirty_bit(TAG_LENGTH);

  state_t           state;
  logic [31:0]      addr_q, d_q;
  logic             wr_q;
  logic [OFS_W-1:0] cnt;
  logic [TAG_W-1:0] old_tag;
  logic [TAG_W-1:0] tag_q;
  logic [IDX_W-1:0] idx_q;
  logic             hit, last, rf_ack;
  logic             unused_ok;

  assign tag_q     = addr_q[31:ADDR_LSB];
  assign idx_q     = addr_q[ADDR_LSB-1:OFS_W+2];
  assign hit       = tag_out[VB] && (tag_out[TAG_W-1:0] == tag_q);
  assign last      = (cnt == OFS_W'(WORDS_PER_BLOCK - 1));
  assign rf_ack    = (state == S_RF_REQ) && mem_rd && mem_ready;
  assign unused_ok = ^{a[1:0], addr_q[1:0], tag_out};

  function automatic logic [TAG_LENGTH-1:0] entry(input logic dirty, input logic [TAG_W-1:0] t);
    entry            = '0;
    entry[VB]        = 1'b1;
    entry[DB]        = dirty;
    entry[TAG_W-1:0] = t;
  endfunction

  // Way port is steered combinationally so the RAM sees the address in the
  // same cycle the FSM decides on it (hit data is ready in LOOKUP).
  always_comb begin
    way_a  = '0;
    way_d  = '0;
    way_we = 1'b0;
    tag_we = 1'b0;
    tag_in = '0;
    case (state)
      S_IDLE: way_a = {a[31:2], 2'b00};
      S_LOOKUP, S_REPLAY: begin
        way_a = addr_q;
        if (state == S_LOOKUP && hit && wr_q) begin
          way_we = 1'b1;
          way_d  = d_q;
          tag_we = 1'b1;
          tag_in = entry(1'b1, tag_q);
        end
      end
      S_WB_RD, S_WB_WR: way_a = {{TAG_W{1'b0}}, idx_q, cnt, 2'b00};
      S_RF_REQ: begin
        way_a = {tag_q, idx_q, cnt, 2'b00};
        if (rf_ack) begin
          way_we = 1'b1;
          way_d  = mem_spo;
          if (last) begin
            tag_we = 1'b1;
            tag_in = entry(1'b0, tag_q);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_WAIT_INIT;
      addr_q  <= '0;
      d_q     <= '0;
      wr_q    <= 1'b0;
      cnt     <= '0;
      old_tag <= '0;
      spo     <= '0;
      ready   <= 1'b0;
      way_en  <= 1'b0;
      mem_a   <= '0;
      mem_d   <= '0;
      mem_we  <= 1'b0;
      mem_rd  <= 1'b0;
    end else begin
      way_en <= 1'b1;
      ready  <= 1'b0;
      case (state)
        S_WAIT_INIT: if (way_init_done) state <= S_IDLE;
        S_IDLE: if (rd || we) begin
          addr_q <= {a[31:2], 2'b00};
          d_q    <= d;
          wr_q   <= we;
          state  <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (hit) begin
            if (!wr_q) spo <= way_spo;
            ready <= 1'b1;
            state <= S_DONE;
          end else begin
            cnt     <= '0;
            old_tag <= tag_out[TAG_W-1:0];
            state   <= (tag_out[VB] && tag_out[DB]) ? S_WB_RD : S_RF_REQ;
          end
        end
        S_WB_RD: state <= S_WB_WR;
        // First WB_WR cycle captures the RAM word, then the write is held.
        S_WB_WR: begin
          if (!mem_we) begin
            mem_we <= 1'b1;
            mem_a  <= {old_tag, idx_q, cnt, 2'b00};
            mem_d  <= way_spo;
          end else if (mem_ready) begin
            mem_we <= 1'b0;
            cnt    <= cnt + 1'b1;
            state  <= last ? S_RF_REQ : S_WB_RD;
          end
        end
        S_RF_REQ: begin
          if (!mem_rd) begin
            mem_rd <= 1'b1;
            mem_a  <= {tag_q, idx_q, cnt, 2'b00};
          end else if (mem_ready) begin
            mem_rd <= 1'b0;
            cnt    <= cnt + 1'b1;
            if (last) state <= S_REPLAY;
          end
        end
        // Re-present the request address so the RAM output is valid in LOOKUP.
        S_REPLAY: state <= S_LOOKUP;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_WAIT_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural cache way and memory around the DUT,
// checked against a word-level shadow memory plus resident-tag bookkeeping.
module tb_cache_ctrl;

  localparam int LINES = 4;
  localparam int WPB   = 4;
  localparam int TL    = 32;
  localparam int TMO   = 2000;

  logic          clk, rst;
  logic [31:0]   a, d, spo;
  logic          we, rd, ready;
  logic          way_en, way_we, tag_we, way_init_done;
  logic [31:0]   way_a, way_d, way_spo;
  logic [TL-1:0] tag_in, tag_out;
  logic [31:0]   mem_a, mem_d, mem_spo;
  logic          mem_we, mem_rd, mem_ready;

  cache_ctrl #(.LINES(LINES), .WORDS_PER_BLOCK(WPB), .TAG_LENGTH(TL)) dut (
    .clk(clk), .rst(rst), .a(a), .d(d), .we(we), .rd(rd), .spo(spo), .ready(ready),
    .way_en(way_en), .way_a(way_a), .way_d(way_d), .way_we(way_we), .way_spo(way_spo),
    .tag_we(tag_we), .tag_in(tag_in), .tag_out(tag_out), .way_init_done(way_init_done),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_spo(mem_spo), .mem_ready(mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Cache way: 1-cycle data RAM, combinational tags, tag clear after reset.
  logic [31:0]   wdata [0:LINES*WPB-1];
  logic [TL-1:0] wtag  [0:LINES-1];
  int            init_cnt;

  assign tag_out       = wtag[way_a[5:4]];
  assign way_init_done = (init_cnt == LINES);

  always @(posedge clk or negedge rst) begin
    if (!rst) init_cnt <= 0;
    else if (init_cnt < LINES) begin
      wtag[init_cnt] <= '0;
      init_cnt       <= init_cnt + 1;
    end else if (tag_we) wtag[way_a[5:4]] <= tag_in;
  end

  always @(posedge clk) begin
    if (way_we) wdata[way_a[5:2]] <= way_d;
    way_spo <= wdata[way_a[5:2]];
  end

  // Memory: 4 KB of words, random 0-5 cycle response, one-cycle mem_ready.
  logic [31:0] mem_arr [0:1023];
  logic [31:0] rlog [0:15];
  logic [31:0] wlog_a [0:15];
  logic [31:0] wlog_d [0:15];
  int          n_rd, n_wr, proto_bad;

  initial begin
    int  dly;
    bit  pend;
    int  w;
    mem_ready = 1'b0; mem_spo = '0;
    n_rd = 0; n_wr = 0; proto_bad = 0; dly = 0; pend = 0;
    for (int i = 0; i < 1024; i++) mem_arr[i] = 32'(i * 4) ^ 32'hA5A5A5A5;
    forever begin
      @(posedge clk); #1;
      if (mem_rd && mem_we) proto_bad++;
      if (!rst) begin
        mem_ready = 1'b0;
        pend      = 0;
      end else if (mem_ready) begin
        mem_ready = 1'b0;
        if (mem_rd || mem_we) proto_bad++;
      end else if (mem_rd || mem_we) begin
        if (!pend) begin
          pend = 1;
          dly  = $urandom_range(0, 5);
        end
        if (dly == 0) begin
          pend      = 0;
          mem_ready = 1'b1;
          w         = int'(mem_a[11:2]);
          if (mem_we) begin
            mem_arr[w]       = mem_d;
            wlog_a[n_wr%16]  = mem_a;
            wlog_d[n_wr%16]  = mem_d;
            n_wr++;
          end else begin
            mem_spo         = mem_arr[w];
            rlog[n_rd%16]   = mem_a;
            n_rd++;
          end
        end else dly--;
      end
    end
  end

  // Reference: CPU-visible word values and which tag each line holds.
  logic [31:0] shadow [0:1023];
  bit          res_v [0:LINES-1];
  bit          res_d [0:LINES-1];
  logic [25:0] res_tag [0:LINES-1];
  int          checks, errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic w, input logic [31:0] addr,
                       input logic [31:0] data, output logic [31:0] got);
    int          idx, cyc, rd0, wr0, erd, ewr;
    logic [25:0] tg;
    bit          hit;
    logic [31:0] exp_v;
    idx   = int'(addr[5:4]);
    tg    = addr[31:6];
    hit   = res_v[idx] && (res_tag[idx] == tg);
    erd   = hit ? 0 : WPB;
    ewr   = (!hit && res_v[idx] && res_d[idx]) ? WPB : 0;
    exp_v = shadow[addr[11:2]];
    rd0 = n_rd; wr0 = n_wr;
    a = addr; d = data; we = w; rd = !w; cyc = 0;
    while (cyc < TMO) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) break;
    end
    got = spo;
    we = 1'b0; rd = 1'b0;
    @(posedge clk); #1;
    check({tag, " ready"}, 32'(cyc < TMO), 32'd1);
    if (!w) check({tag, " spo"}, got, exp_v);
    check({tag, " mem reads"}, 32'(n_rd - rd0), 32'(erd));
    check({tag, " mem writes"}, 32'(n_wr - wr0), 32'(ewr));
    if (hit) check({tag, " hit latency"}, 32'(cyc), 32'd2);
    res_v[idx] = 1; res_tag[idx] = tg;
    if (!hit) res_d[idx] = 0;
    if (w) begin
      res_d[idx]          = 1;
      shadow[addr[11:2]]  = data;
    end
  endtask

  initial begin
    logic [31:0] got, addr;
    int          base, k;
    bit          bad;
    checks = 0; errors = 0;
    rst = 1'b0; a = '0; d = '0; we = 1'b0; rd = 1'b0;
    for (int i = 0; i < 1024; i++) shadow[i] = 32'(i * 4) ^ 32'hA5A5A5A5;
    for (int i = 0; i < LINES; i++) begin res_v[i] = 0; res_d[i] = 0; res_tag[i] = '0; end

    // Reset state, then nothing may happen while the way initialises.
    repeat (3) @(posedge clk);
    #1;
    check("reset ctl", {26'd0, ready, way_en, way_we, tag_we, mem_rd, mem_we}, 32'd0);
    check("reset spo", spo, 32'd0);
    check("reset mem_a", mem_a, 32'd0);
    rst = 1'b1; a = 32'h40; rd = 1'b1; bad = 0; k = 0;
    while (!way_init_done && k < 100) begin
      if (way_we || tag_we || mem_rd || mem_we || ready) bad = 1;
      @(posedge clk); #1;
      k++;
    end
    rd = 1'b0;
    check("init done", 32'(way_init_done), 32'd1);
    check("quiet during init", 32'(bad), 32'd0);

    // Cold read: four refill reads of the line.
    base = n_rd;
    do_op("cold rd 0x40", 1'b0, 32'h40, '0, got);
    check("cold spo", got, 32'hA5A5A5E5);
    for (int i = 0; i < 4; i++) check("refill addr", rlog[(base + i) % 16], 32'h40 + 32'(i * 4));

    do_op("hit rd 0x44", 1'b0, 32'h44, '0, got);
    check("hit spo", got, 32'hA5A5A5E1);
    do_op("hit wr 0x48", 1'b1, 32'h48, 32'hDEADBEEF, got);
    do_op("rd 0x48", 1'b0, 32'h48, '0, got);
    check("rd back 0x48", got, 32'hDEADBEEF);

    // Conflict on a dirty line: writeback then refill.
    base = n_wr;
    do_op("evict rd 0x140", 1'b0, 32'h140, '0, got);
    check("evict spo", got, 32'hA5A5A4E5);
    for (int i = 0; i < 4; i++) begin
      check("wb addr", wlog_a[(base + i) % 16], 32'h40 + 32'(i * 4));
      check("wb data", wlog_d[(base + i) % 16],
            (i == 2) ? 32'hDEADBEEF : ((32'h40 + 32'(i * 4)) ^ 32'hA5A5A5A5));
    end

    // Random traffic over 0x200-0x3FC (tags 8..15, all indexes).
    for (int i = 0; i < 40; i++) begin
      addr = 32'h200 + (32'($urandom_range(0, 127)) << 2);
      do_op("random", 1'($urandom_range(0, 1)), addr, $urandom, got);
    end

    // Reset in the middle of a refill.
    addr = (res_v[0] && res_tag[0] == 26'd8) ? 32'h240 : 32'h200;
    a = addr; rd = 1'b1; k = 0;
    while (!mem_rd && k < TMO) begin
      @(posedge clk); #1;
      k++;
    end
    check("refill started", 32'(mem_rd), 32'd1);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("mid reset ctl", {26'd0, ready, way_en, way_we, tag_we, mem_rd, mem_we}, 32'd0);
    check("mid reset mem_a", mem_a, 32'd0);
    check("mid reset way_a", way_a, 32'd0);
    rd = 1'b0;
    for (int i = 0; i < LINES; i++) res_v[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; k = 0;
    while (!way_init_done && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("re-init done", 32'(way_init_done), 32'd1);
    do_op("post-reset rd 0x140", 1'b0, 32'h140, '0, got);
    check("post-reset 0x140", got, 32'hA5A5A4E5);
    do_op("post-reset rd 0x48", 1'b0, 32'h48, '0, got);
    check("post-reset 0x48", got, 32'hDEADBEEF);
    check("mem protocol", 32'(proto_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
